status_cond_unit: RTL
=====================

STATUS_COND_UNIT -- requirements
Module: status_cond_unit

Interface
REQ-001 Parameter MAX_PENDING, default 3: saturation limit of the in-flight flag-writer counter; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 status_in  input  4  ALU flags, ordered {Z,C,N,V}.
REQ-005 s_update  input  1  the EXE-stage instruction writes the flags this cycle.
REQ-006 s_issue  input  1  the instruction leaving ID carries the S bit.
REQ-007 cond  input  4  ARM condition field of the instruction in ID.
REQ-008 cond_valid  input  1  the instruction in ID requests condition evaluation.
REQ-009 flush  input  1  taken branch; kills younger in-flight instructions.
REQ-010 status_out  output  4  registered flags, ordered {Z,C,N,V}.
REQ-011 carry_out  output  1  equals status_out[2]; drives the ALU carry_in.
REQ-012 hazard_stall  output  1  combinational; holds ID while flags are pending.
REQ-013 cond_pass  output  1  registered condition result.
REQ-014 cond_pass_valid  output  1  registered; qualifies cond_pass.

Function
REQ-015 The status register SHALL load status_in on a clock edge where s_update=1, and SHALL hold its value otherwise.
REQ-016 A pending counter SHALL count up on an accepted s_issue (s_issue=1 and hazard_stall=0) and count down on s_update, with no change when both or neither occur.
REQ-017 The pending counter SHALL saturate at MAX_PENDING and at 0; s_update with pending=0 SHALL still write the flags.
REQ-018 flush=1 SHALL clear pending to 0 on that edge, overriding s_issue and s_update counting; a same-cycle s_update SHALL still write the flags.
REQ-019 hazard_stall SHALL be cond_valid AND (pending != 0), subject to REQ-030.
REQ-020 When cond_valid=1 and hazard_stall=0, on the next edge cond_valid registers as cond_pass_valid=1 and cond_pass = eval(cond, flags); otherwise cond_pass_valid=0 and cond_pass holds its value.
REQ-021 eval SHALL use this table: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-022 The evaluation latency SHALL be exactly one cycle from the accepting edge; there SHALL be no bubble between back-to-back accepted evaluations.
REQ-023 flush=1 SHALL force cond_pass_valid=0 on the next edge.
REQ-024 The flags used by eval SHALL be status_out as it is before the edge, except as stated in REQ-030.

Reset
REQ-025 With rst=1 at an edge, status_out SHALL become 4'b0000, pending 0, cond_pass 0 and cond_pass_valid 0.
REQ-026 rst SHALL override flush, s_update and s_issue in the same cycle.
REQ-027 hazard_stall SHALL be 0 in the cycle following a reset edge unless cond_valid coincides with new pending state.
REQ-028 A reset asserted mid-stall SHALL drop hazard_stall on the next cycle, because pending becomes 0.

Configuration
REQ-029 The macro COND_FORWARD_EN SHALL select the forwarding feature.
REQ-030 With COND_FORWARD_EN defined: when pending=1 and s_update=1, hazard_stall SHALL be 0 and eval SHALL use status_in instead of status_out.
REQ-031 Without COND_FORWARD_EN, the block SHALL stall whenever pending != 0, and eval SHALL always use status_out.

Verification
REQ-032 Reset, then s_update=1 with status_in=4'b1000, then cond=0000 with cond_valid=1: one cycle later cond_pass=1 and cond_pass_valid=1.
REQ-033 Step through all 16 cond values with flags {Z,C,N,V}=0110 loaded: the results SHALL match the REQ-021 table (e.g. HI=1, GE=0, AL=1, 1111=0).
REQ-034 s_issue=1, then cond_valid=1 on the next cycle: hazard_stall=1 until the s_update cycle. With COND_FORWARD_EN the stall drops in the s_update cycle and the result uses status_in; without it the stall drops one cycle later.
REQ-035 Two accepted s_issue then flush=1: pending=0 and hazard_stall=0 on the next cycle, and cond_pass_valid=0.
REQ-036 s_issue and s_update asserted together with pending=1: pending stays 1 and the flags update to status_in.
REQ-037 rst=1 during a stall with status_out=4'b1111: the next cycle shows status_out=0000, carry_out=0, hazard_stall=0 and cond_pass_valid=0.

Source files
------------

// File: rtl/status_cond_unit.sv
// status_cond_unit: registered {Z,C,N,V} flags, ARM condition evaluation and flag-hazard stall.
// Define COND_FORWARD_EN to forward status_in into evaluation when the last pending writer updates.
module status_cond_unit #(
  parameter int MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] status_in,
  input  logic       s_update,
  input  logic       s_issue,
  input  logic [3:0] cond,
  input  logic       cond_valid,
  input  logic       flush,
  output logic [3:0] status_out,
  output logic       carry_out,
  output logic       hazard_stall,
  output logic       cond_pass,
  output logic       cond_pass_valid
);
  localparam logic [1:0] MAX = 2'(MAX_PENDING);
  logic [1:0] pending;
  logic       fwd, accept, inc, base;
  logic [3:0] flags;
`ifdef COND_FORWARD_EN
  assign fwd = s_update && pending == 2'd1;
`else
  assign fwd = 1'b0;
`endif
  assign hazard_stall = cond_valid && pending != 2'd0 && !fwd;
  assign flags        = fwd ? status_in : status_out;
  assign carry_out    = status_out[2];
  assign accept       = cond_valid && !hazard_stall;
  assign inc          = s_issue && !hazard_stall;
  // odd condition codes are the complement of the preceding even code
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0: base = flags[3];
      3'd1: base = flags[2];
      3'd2: base = flags[1];
      3'd3: base = flags[0];
      3'd4: base = flags[2] && !flags[3];
      3'd5: base = flags[1] == flags[0];
      3'd6: base = !flags[3] && (flags[1] == flags[0]);
      default: base = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      status_out      <= 4'b0000;
      pending         <= 2'd0;
      cond_pass       <= 1'b0;
      cond_pass_valid <= 1'b0;
    end else begin
      if (s_update) status_out <= status_in;
      if (flush) pending <= 2'd0;
      else if (inc && !s_update && pending != MAX) pending <= pending + 2'd1;
      else if (s_update && !inc && pending != 2'd0) pending <= pending - 2'd1;
      if (accept) cond_pass <= base ^ cond[0];
      cond_pass_valid <= accept && !flush;
    end
  end
endmodule
